// File: rtl/gpio_irq_apb4.sv
// gpio_irq_apb4 -- APB4 GPIO bank with per-pin direction, atomic output
// set/clear, synchronised inputs and per-pin edge/level interrupts.
//
// Configuration macro: GPIO_IRQ_EN
//   defined   : IRQ_EN / IRQ_TYPE / IRQ_POL / IRQ_STAT registers and the
//               edge-detect flop are built; irq_o reflects pending enabled pins.
//   undefined : offsets 0x14-0x20 read 0 and ignore writes, irq_o tied 0.
//
// Parameters:
//   GPIO_NUM    requested pin count, clamped to the 32-bit bus (GPIO_NUM_)
//   SYNC_STAGES input synchroniser depth, clamped to 2..4
//   ADDR_W      PADDR width; word offsets above 0x20 raise PSLVERR
//
// Ports:
//   PCLK, PRESETn                   APB clock, async active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA APB request
//   PRDATA/PREADY/PSLVERR           APB response (PREADY always 1)
//   io_pin_i                        raw pad inputs (asynchronous)
//   io_pin_o / io_oe_o              pad output values / output enables
//   irq_o                           level interrupt
//
// Register map (word offsets): 0x00 DIR, 0x04 OUT, 0x08 IN, 0x0C OUT_SET,
// 0x10 OUT_CLR, 0x14 IRQ_EN, 0x18 IRQ_TYPE (1 edge), 0x1C IRQ_POL (1 rise/high),
// 0x20 IRQ_STAT (write 1 to clear).

module gpio_irq_apb4 #(
   parameter int  GPIO_NUM    = 16,
   parameter int  SYNC_STAGES = 2,
   parameter int  ADDR_W      = 12,
   localparam int MEM_BUS     = 32,
   localparam int GPIO_NUM_   = (GPIO_NUM < MEM_BUS) ? GPIO_NUM : MEM_BUS
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic [ADDR_W-1:0]    PADDR,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [MEM_BUS-1:0]   PWDATA,
   output logic [MEM_BUS-1:0]   PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   input  logic [GPIO_NUM_-1:0] io_pin_i,
   output logic [GPIO_NUM_-1:0] io_pin_o,
   output logic [GPIO_NUM_-1:0] io_oe_o,
   output logic                 irq_o
);

   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

   logic [ADDR_W-3:0]    offset;
   logic                 unmapped;
   logic                 setup_ph;
   logic                 wr_en;
   logic [GPIO_NUM_-1:0] wdata;
   logic                 unused_bits;

   logic [GPIO_NUM_-1:0] dir_q, dir_d;
   logic [GPIO_NUM_-1:0] out_q, out_d;
   logic [GPIO_NUM_-1:0] sync_chain_q [SYNC_N];
   logic [GPIO_NUM_-1:0] sync_chain_d [SYNC_N];
   logic [GPIO_NUM_-1:0] sync_in;
   logic [MEM_BUS-1:0]   prdata_q, prdata_d;
   logic                 pslverr_q, pslverr_d;
   logic [GPIO_NUM_-1:0] rd_gpio;

   assign offset      = PADDR[ADDR_W-1:2];
   assign unmapped    = offset > (ADDR_W-2)'(8);
   assign setup_ph    = PSEL & ~PENABLE;
   assign wr_en       = PSEL & PENABLE & PWRITE & ~unmapped;
   assign wdata       = PWDATA[GPIO_NUM_-1:0];
   assign unused_bits = ^{PADDR[1:0], PWDATA};
   assign sync_in     = sync_chain_q[SYNC_N-1];

   assign PREADY   = 1'b1;
   assign PRDATA   = prdata_q;
   assign PSLVERR  = pslverr_q;
   assign io_pin_o = out_q;
   assign io_oe_o  = dir_q;

   // Output-side registers; SET/CLR modify OUT atomically so software never
   // needs a read-modify-write that could race with another bus master.
   always_comb begin
      dir_d = dir_q;
      out_d = out_q;
      if (wr_en) begin
         case (offset[3:0])
            4'h0:    dir_d = wdata;
            4'h1:    out_d = wdata;
            4'h3:    out_d = out_q | wdata;
            4'h4:    out_d = out_q & ~wdata;
            default: ;
         endcase
      end
   end

   // Synchroniser shift chain; the last stage is the first metastability-safe view.
   always_comb begin
      sync_chain_d[0] = io_pin_i;
      for (int s = 1; s < SYNC_N; s++) begin
         sync_chain_d[s] = sync_chain_q[s-1];
      end
   end

`ifdef GPIO_IRQ_EN
   logic [GPIO_NUM_-1:0] irq_en_q, irq_en_d;
   logic [GPIO_NUM_-1:0] irq_type_q, irq_type_d;
   logic [GPIO_NUM_-1:0] irq_pol_q, irq_pol_d;
   logic [GPIO_NUM_-1:0] irq_stat_q, irq_stat_d;
   logic [GPIO_NUM_-1:0] sync_prev_q;
   logic [GPIO_NUM_-1:0] stat_clr;
   logic [GPIO_NUM_-1:0] pol_match;
   logic [GPIO_NUM_-1:0] irq_event;

   // Interrupt configuration and pending status. An event in the same cycle
   // as a W1C wins, so a level source that is still active re-sets at once.
   always_comb begin
      irq_en_d   = irq_en_q;
      irq_type_d = irq_type_q;
      irq_pol_d  = irq_pol_q;
      stat_clr   = '0;
      if (wr_en) begin
         case (offset[3:0])
            4'h5:    irq_en_d   = wdata;
            4'h6:    irq_type_d = wdata;
            4'h7:    irq_pol_d  = wdata;
            4'h8:    stat_clr   = wdata;
            default: ;
         endcase
      end
      pol_match  = ~(sync_in ^ irq_pol_q);
      irq_event  = pol_match & (~irq_type_q | (sync_in ^ sync_prev_q));
      irq_stat_d = (irq_stat_q & ~stat_clr) | irq_event;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         irq_en_q    <= '0;
         irq_type_q  <= '0;
         irq_pol_q   <= '0;
         irq_stat_q  <= '0;
         sync_prev_q <= '0;
      end else begin
         irq_en_q    <= irq_en_d;
         irq_type_q  <= irq_type_d;
         irq_pol_q   <= irq_pol_d;
         irq_stat_q  <= irq_stat_d;
         sync_prev_q <= sync_in;
      end
   end

   assign irq_o = |(irq_stat_q & irq_en_q);
`else
   assign irq_o = 1'b0;
`endif

   // Read mux; write-only and absent registers fall through to zero.
   always_comb begin
      rd_gpio = '0;
      case (offset[3:0])
         4'h0:    rd_gpio = dir_q;
         4'h1:    rd_gpio = out_q;
         4'h2:    rd_gpio = sync_in;
`ifdef GPIO_IRQ_EN
         4'h5:    rd_gpio = irq_en_q;
         4'h6:    rd_gpio = irq_type_q;
         4'h7:    rd_gpio = irq_pol_q;
         4'h8:    rd_gpio = irq_stat_q;
`endif
         default: rd_gpio = '0;
      endcase
   end

   // Response is captured in the setup phase so it is stable for the whole
   // access phase; PSLVERR drops again once the access phase ends.
   always_comb begin
      prdata_d  = prdata_q;
      pslverr_d = 1'b0;
      if (setup_ph) begin
         prdata_d  = unmapped ? '0 : MEM_BUS'(rd_gpio);
         pslverr_d = unmapped;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         dir_q        <= '0;
         out_q        <= '0;
         sync_chain_q <= '{default: '0};
         prdata_q     <= '0;
         pslverr_q    <= 1'b0;
      end else begin
         dir_q        <= dir_d;
         out_q        <= out_d;
         sync_chain_q <= sync_chain_d;
         prdata_q     <= prdata_d;
         pslverr_q    <= pslverr_d;
      end
   end

endmodule
